// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute slot with operand select and ALU op decode.
// Macro FORWARDING_EN enables the EX/MEM and MEM/WB operand bypass.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [4:0]      rs1_addr_in,
  input  logic [4:0]      rs2_addr_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            alu_src_a_in,
  input  logic            alu_src_b_in,
  input  logic [1:0]      alu_class_in,
  input  logic [2:0]      funct3_in,
  input  logic            funct7_5_in,
  input  logic            reg_write_in,
  input  logic [4:0]      ex_mem_rd,
  input  logic [4:0]      mem_wb_rd,
  input  logic            ex_mem_reg_write,
  input  logic            mem_wb_reg_write,
  input  logic [XLEN-1:0] ex_mem_value,
  input  logic [XLEN-1:0] mem_wb_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_operation,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic [2:0]      funct3_out
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rs1_addr_q;
  logic [4:0]      rs2_addr_q;
  logic [4:0]      rd_q;
  logic            src_a_q;
  logic            src_b_q;
  logic            reg_write_q;
  logic [2:0]      funct3_q;
  logic [3:0]      op_q;
  logic [3:0]      op_d;
  logic            accept;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    op_d = OP_ADD;
    case (alu_class_in)
      2'b01: begin
        case (funct3_in[2:1])
          2'b00:   op_d = OP_SUB;
          2'b10:   op_d = OP_SLT;
          2'b11:   op_d = OP_SLTU;
          default: op_d = OP_ADD;
        endcase
      end
      2'b10, 2'b11: begin
        case (funct3_in)
          // I-type has no subtract; instr[30] is immediate bits there
          3'b000:  op_d = (funct7_5_in && !alu_class_in[0]) ? OP_SUB : OP_ADD;
          3'b001:  op_d = OP_SLL;
          3'b010:  op_d = OP_SLT;
          3'b011:  op_d = OP_SLTU;
          3'b100:  op_d = OP_XOR;
          3'b101:  op_d = funct7_5_in ? OP_SRA : OP_SRL;
          3'b110:  op_d = OP_OR;
          default: op_d = OP_AND;
        endcase
      end
      default: op_d = OP_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      src_a_q     <= 1'b0;
      src_b_q     <= 1'b0;
      reg_write_q <= 1'b0;
      funct3_q    <= '0;
      op_q        <= OP_ADD;
    end else if (accept) begin
      pc_q        <= pc_in;
      rs1_q       <= rs1_data_in;
      rs2_q       <= rs2_data_in;
      imm_q       <= imm_in;
      rs1_addr_q  <= rs1_addr_in;
      rs2_addr_q  <= rs2_addr_in;
      rd_q        <= rd_in;
      src_a_q     <= alu_src_a_in;
      src_b_q     <= alu_src_b_in;
      reg_write_q <= reg_write_in;
      funct3_q    <= funct3_in;
      op_q        <= op_d;
    end
  end

`ifdef FORWARDING_EN
  // EX/MEM is younger than MEM/WB, so it wins when both match
  always_comb begin
    fwd_rs1 = rs1_q;
    if (rs1_addr_q != 5'd0 && ex_mem_reg_write &&
        ex_mem_rd == rs1_addr_q) begin
      fwd_rs1 = ex_mem_value;
    end else if (rs1_addr_q != 5'd0 && mem_wb_reg_write &&
                 mem_wb_rd == rs1_addr_q) begin
      fwd_rs1 = mem_wb_value;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_q;
    if (rs2_addr_q != 5'd0 && ex_mem_reg_write &&
        ex_mem_rd == rs2_addr_q) begin
      fwd_rs2 = ex_mem_value;
    end else if (rs2_addr_q != 5'd0 && mem_wb_reg_write &&
                 mem_wb_rd == rs2_addr_q) begin
      fwd_rs2 = mem_wb_value;
    end
  end
`else
  // Decode interlock guarantees the register file data is current
  logic unused_fwd;
  assign unused_fwd = ^{ex_mem_rd, mem_wb_rd, ex_mem_reg_write,
                        mem_wb_reg_write, ex_mem_value, mem_wb_value,
                        rs1_addr_q, rs2_addr_q};
  assign fwd_rs1 = rs1_q;
  assign fwd_rs2 = rs2_q;
`endif

  assign out_valid     = valid_q;
  assign operand_a     = src_a_q ? pc_q : fwd_rs1;
  assign operand_b     = src_b_q ? imm_q : fwd_rs2;
  assign store_data    = fwd_rs2;
  assign alu_operation = op_q;
  assign pc_out        = pc_q;
  assign rd_out        = rd_q;
  assign reg_write_out = reg_write_q && valid_q;
  assign funct3_out    = funct3_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage
// against a single-slot scoreboard model.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  rd;
    logic        sa;
    logic        sb;
    logic [1:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic        rw;
  } ins_t;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] rs1_data_in = '0;
  logic [31:0] rs2_data_in = '0;
  logic [4:0]  rs1_addr_in = '0;
  logic [4:0]  rs2_addr_in = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] imm_in = '0;
  logic        alu_src_a_in = 1'b0;
  logic        alu_src_b_in = 1'b0;
  logic [1:0]  alu_class_in = '0;
  logic [2:0]  funct3_in = '0;
  logic        funct7_5_in = 1'b0;
  logic        reg_write_in = 1'b0;
  logic [4:0]  ex_mem_rd = '0;
  logic [4:0]  mem_wb_rd = '0;
  logic        ex_mem_reg_write = 1'b0;
  logic        mem_wb_reg_write = 1'b0;
  logic [31:0] ex_mem_value = '0;
  logic [31:0] mem_wb_value = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_operation;
  logic [31:0] store_data;
  logic [31:0] pc_out;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic [2:0]  funct3_out;

  int   n_tests = 0;
  int   n_fail = 0;
  ins_t cur = '0;
  ins_t m = '0;
  logic m_valid = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .pc_in(pc_in), .rs1_data_in(rs1_data_in),
    .rs2_data_in(rs2_data_in), .rs1_addr_in(rs1_addr_in),
    .rs2_addr_in(rs2_addr_in), .rd_in(rd_in), .imm_in(imm_in),
    .alu_src_a_in(alu_src_a_in), .alu_src_b_in(alu_src_b_in),
    .alu_class_in(alu_class_in), .funct3_in(funct3_in),
    .funct7_5_in(funct7_5_in), .reg_write_in(reg_write_in),
    .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_reg_write(mem_wb_reg_write),
    .ex_mem_value(ex_mem_value), .mem_wb_value(mem_wb_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand_a(operand_a), .operand_b(operand_b),
    .alu_operation(alu_operation), .store_data(store_data),
    .pc_out(pc_out), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .funct3_out(funct3_out)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_op(input logic [1:0] cls,
                                        input logic [2:0] f3,
                                        input logic f7);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    if (cls == 2'd0) return 4'd0;
    if (cls == 2'd1) begin
      if (f3 < 3'd2) return 4'd1;
      if (f3 < 3'd4) return 4'd0;
      if (f3 < 3'd6) return 4'd8;
      return 4'd9;
    end
    if (f3 == 3'd0) return (cls == 2'd2 && f7) ? 4'd1 : 4'd0;
    if (f3 == 3'd5) return f7 ? 4'd7 : 4'd6;
    return tbl[f3];
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] a,
                                          input logic [31:0] rf);
    if (FWD && a != 0 && ex_mem_reg_write && ex_mem_rd == a)
      return ex_mem_value;
    if (FWD && a != 0 && mem_wb_reg_write && mem_wb_rd == a)
      return mem_wb_value;
    return rf;
  endfunction

  function automatic ins_t rand_ins();
    ins_t x;
    x.pc   = $urandom;
    x.rs1d = $urandom;
    x.rs2d = $urandom;
    x.imm  = $urandom;
    x.a1   = 5'($urandom_range(0, 7));
    x.a2   = 5'($urandom_range(0, 7));
    x.rd   = 5'($urandom);
    x.sa   = 1'($urandom);
    x.sb   = 1'($urandom);
    x.cls  = 2'($urandom);
    x.f3   = 3'($urandom);
    x.f7   = 1'($urandom);
    x.rw   = 1'($urandom);
    return x;
  endfunction

  task automatic drive(input ins_t x);
    cur          = x;
    pc_in        = x.pc;
    rs1_data_in  = x.rs1d;
    rs2_data_in  = x.rs2d;
    imm_in       = x.imm;
    rs1_addr_in  = x.a1;
    rs2_addr_in  = x.a2;
    rd_in        = x.rd;
    alu_src_a_in = x.sa;
    alu_src_b_in = x.sb;
    alu_class_in = x.cls;
    funct3_in    = x.f3;
    funct7_5_in  = x.f7;
    reg_write_in = x.rw;
  endtask

  task automatic check_model();
    logic [31:0] fa;
    logic [31:0] fb;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    check("reg_write_out", 32'(reg_write_out), 32'(m_valid && m.rw));
    if (m_valid) begin
      fa = ref_fwd(m.a1, m.rs1d);
      fb = ref_fwd(m.a2, m.rs2d);
      check("operand_a", operand_a, m.sa ? m.pc : fa);
      check("operand_b", operand_b, m.sb ? m.imm : fb);
      check("store_data", store_data, fb);
      check("alu_operation", 32'(alu_operation),
            32'(ref_op(m.cls, m.f3, m.f7)));
      check("pc_out", pc_out, m.pc);
      check("rd_out", 32'(rd_out), 32'(m.rd));
      check("funct3_out", 32'(funct3_out), 32'(m.f3));
    end
  endtask

  // One cycle: check, clock edge, advance model, return at negedge
  task automatic step();
    logic acc;
    #1 check_model();
    acc = in_valid && (!m_valid || out_ready) && !flush;
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m = cur;
      m_valid = 1'b1;
    end else if (out_ready) m_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic ins_t mk(input logic [31:0] r1, input logic [31:0] r2,
                              input logic [1:0] cls, input logic [2:0] f3,
                              input logic f7);
    ins_t x;
    x = '0;
    x.pc = 32'h100;
    x.rs1d = r1;
    x.rs2d = r2;
    x.a1 = 5'd1;
    x.a2 = 5'd2;
    x.rd = 5'd3;
    x.rw = 1'b1;
    x.cls = cls;
    x.f3 = f3;
    x.f7 = f7;
    return x;
  endfunction

  initial begin
    ins_t x;
    logic [31:0] hold_a;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst alu_op", 32'(alu_operation), 32'd0);
    check("rst operand_a", operand_a, 32'd0);
    check("rst operand_b", operand_b, 32'd0);
    check("rst store_data", store_data, 32'd0);
    check("rst pc_out", pc_out, 32'd0);
    check("rst rd_out", 32'(rd_out), 32'd0);
    check("rst reg_write", 32'(reg_write_out), 32'd0);
    check("rst funct3", 32'(funct3_out), 32'd0);

    // R-type add then sub
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive(mk(32'd5, 32'd7, 2'd2, 3'd0, 1'b0));
    step();
    check("add valid", 32'(out_valid), 32'd1);
    check("add opa", operand_a, 32'd5);
    check("add opb", operand_b, 32'd7);
    check("add op", 32'(alu_operation), 32'h0);
    drive(mk(32'd5, 32'd7, 2'd2, 3'd0, 1'b1));
    step();
    check("sub op", 32'(alu_operation), 32'h1);

    // srai and bltu
    x = mk(32'd9, 32'd1, 2'd3, 3'd5, 1'b1);
    x.imm = 32'd3;
    x.sb = 1'b1;
    drive(x);
    step();
    check("srai op", 32'(alu_operation), 32'h7);
    check("srai opb", operand_b, 32'd3);
    drive(mk(32'd1, 32'd2, 2'd1, 3'd6, 1'b0));
    step();
    check("bltu op", 32'(alu_operation), 32'h9);

    // Forwarding priority on held rs1 = x4
    x = mk(32'h11, 32'h22, 2'd0, 3'd0, 1'b0);
    x.a1 = 5'd4;
    drive(x);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    ex_mem_rd = 5'd4;
    ex_mem_value = 32'hAA;
    ex_mem_reg_write = 1'b1;
    mem_wb_rd = 5'd4;
    mem_wb_value = 32'hBB;
    mem_wb_reg_write = 1'b1;
    #1 check("fwd exmem", operand_a, FWD ? 32'hAA : 32'h11);
    ex_mem_reg_write = 1'b0;
    #1 check("fwd memwb", operand_a, FWD ? 32'hBB : 32'h11);
    step();
    ex_mem_reg_write = 1'b0;
    mem_wb_reg_write = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    x = mk(32'h33, 32'h44, 2'd0, 3'd0, 1'b0);
    x.a1 = 5'd0;
    drive(x);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    ex_mem_rd = 5'd0;
    mem_wb_rd = 5'd0;
    ex_mem_reg_write = 1'b1;
    mem_wb_reg_write = 1'b1;
    #1 check("fwd x0", operand_a, 32'h33);
    step();
    ex_mem_reg_write = 1'b0;
    mem_wb_reg_write = 1'b0;

    // Stall three cycles with a new instruction waiting
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive(mk(32'hA1, 32'hA2, 2'd2, 3'd4, 1'b0));
    step();
    out_ready = 1'b0;
    drive(mk(32'hB1, 32'hB2, 2'd2, 3'd6, 1'b0));
    hold_a = operand_a;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall in_ready", 32'(in_ready), 32'd0);
      check("stall opa", operand_a, hold_a);
    end
    out_ready = 1'b1;
    step();
    check("unstall opa", operand_a, 32'hB1);
    check("unstall op", 32'(alu_operation), 32'h3);
    in_valid = 1'b0;
    step();
    check("no dup", 32'(out_valid), 32'd0);

    // Flush while stalled with in_valid high
    in_valid = 1'b1;
    drive(mk(32'hC1, 32'hC2, 2'd0, 3'd0, 1'b0));
    step();
    out_ready = 1'b0;
    flush = 1'b1;
    drive(mk(32'hD1, 32'hD2, 2'd0, 3'd0, 1'b0));
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    step();
    check("flush drop", 32'(out_valid), 32'd0);

    // Asynchronous reset with a live instruction
    in_valid = 1'b1;
    drive(mk(32'hE1, 32'hE2, 2'd2, 3'd0, 1'b1));
    step();
    in_valid = 1'b0;
    check("pre-rst valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async valid", 32'(out_valid), 32'd0);
    check("async rw", 32'(reg_write_out), 32'd0);
    check("async op", 32'(alu_operation), 32'd0);
    m = '0;
    m_valid = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(rand_ins());
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      flush = ($urandom % 16) == 0;
      ex_mem_rd = 5'($urandom_range(0, 7));
      mem_wb_rd = 5'($urandom_range(0, 7));
      ex_mem_reg_write = 1'($urandom);
      mem_wb_reg_write = 1'($urandom);
      ex_mem_value = $urandom;
      mem_wb_value = $urandom;
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register that sits directly upstream of the ALU. It captures decoded instruction fields, resolves forwarding, selects the two ALU operands, and translates the decoder's coarse operation class plus funct3/funct7 into the 4-bit ALU operation code. It implements a single-entry valid/ready slot so the execute stage can stall without losing an instruction.

## Interface
Parameters:
- XLEN, 32, datapath width; operand and result width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  slot can accept this cycle.
- flush  in  1  kill the held instruction (branch mispredict or trap).
- pc_in  in  XLEN  instruction PC.
- rs1_data_in, rs2_data_in  in  XLEN  register-file read data.
- rs1_addr_in, rs2_addr_in, rd_in  in  5  register indices.
- imm_in  in  XLEN  sign-extended immediate.
- alu_src_a_in  in  1  0 = rs1, 1 = PC.
- alu_src_b_in  in  1  0 = rs2, 1 = immediate.
- alu_class_in  in  2  00 add, 01 branch compare, 10 R-type, 11 I-type.
- funct3_in  in  3  instruction funct3.
- funct7_5_in  in  1  instr[30].
- reg_write_in  in  1  instruction writes rd.
- ex_mem_rd, mem_wb_rd  in  5  destinations of the two later stages.
- ex_mem_reg_write, mem_wb_reg_write  in  1  the later stage will write its rd.
- ex_mem_value, mem_wb_value  in  XLEN  result values of the later stages.
- out_valid  out  1  outputs hold a live instruction.
- out_ready  in  1  execute consumes this cycle.
- operand_a, operand_b  out  XLEN  ALU operands.
- alu_operation  out  4  ALU operation code.
- store_data  out  XLEN  forwarded rs2 value.
- pc_out  out  XLEN  held PC.
- rd_out  out  5  held rd.
- reg_write_out  out  1  held reg_write, gated by out_valid.
- funct3_out  out  3  held funct3, used for branch resolution.

## Operation
- Single slot. in_ready = !out_valid | out_ready. Accept when in_valid & in_ready: all *_in fields are latched and out_valid is set.
- When out_valid & out_ready and no new accept occurs, out_valid clears.
- flush has priority over everything. The next edge clears out_valid, and any same-cycle in_valid is dropped. Payload registers may keep stale values.
- ALU operation codes: add 0000, sub 0001, and 0010, or 0011, xor 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001.
  - Class 00: always add.
  - Class 01: funct3 000/001 -> sub; 100/101 -> slt; 110/111 -> sltu; 010/011 -> add.
  - Class 10: funct3 000 -> sub if funct7_5, else add; 001 sll; 010 slt; 011 sltu; 100 xor; 101 -> sra if funct7_5, else srl; 110 or; 111 and.
  - Class 11: same as class 10, except funct3 000 is always add.
  - The code is computed at capture and registered.
- Forwarding is combinational on the held rs1/rs2 addresses and is re-evaluated every cycle while stalled.
  - Source order: EX/MEM first when ex_mem_reg_write and ex_mem_rd == addr and addr != 0; else MEM/WB under the same conditions; else the latched register-file data.
  - Index 0 is never forwarded.
- operand_a = alu_src_a ? pc : fwd_rs1. operand_b = alu_src_b ? imm : fwd_rs2. store_data = fwd_rs2 regardless of alu_src_b.

## Timing
- Latency: 1 cycle from an accepted in_valid to out_valid.
- Throughput: 1 instruction per cycle when out_ready is held high.
- Forwarding outputs settle in the same cycle the later-stage signals change. There is no extra cycle.
- Reset (asynchronous): out_valid = 0, reg_write_out = 0, alu_operation = 0000, and all data outputs and held fields = 0. in_ready = 1 after reset.
- Reset asserted mid-stall discards the held instruction immediately, without waiting for an edge.
- Stall: when out_valid & !out_ready, every held field is stable. in_ready = 0.

## Configuration
- FORWARDING_EN defined: forwarding operates as described in Operation.
- FORWARDING_EN undefined:
  - fwd_rs1/fwd_rs2 are the latched register-file data.
  - The ex_mem_* and mem_wb_* inputs are ignored.
  - Hazards are the responsibility of the decode-stage interlock.

## Test plan
- Reset, then accept R-type add: rs1_data = 5, rs2_data = 7, class 10, funct3 000, funct7_5 = 0 -> next cycle out_valid = 1, operand_a = 5, operand_b = 7, alu_operation = 0000. Same with funct7_5 = 1 -> 0001.
- I-type srai: class 11, funct3 101, funct7_5 = 1, imm = 3, alu_src_b = 1 -> alu_operation = 0111, operand_b = 3. Branch bltu, class 01, funct3 110 -> 1001.
- Forwarding with FORWARDING_EN: held rs1 = x4; ex_mem_rd = 4 with value 0xAA and mem_wb_rd = 4 with value 0xBB, both writing -> operand_a = 0xAA. With ex_mem_reg_write = 0 -> 0xBB. With rs1 = x0 and both stages targeting 0 -> latched data.
- Stall: out_ready = 0 for 3 cycles while in_valid = 1 -> in_ready = 0, outputs constant, no new capture. Then out_ready = 1 -> next instruction appears the following cycle, with no loss or duplication.
- Flush while stalled with in_valid = 1 -> next cycle out_valid = 0, the incoming instruction is dropped, in_ready = 1.
- Assert rst while out_valid = 1 -> out_valid, reg_write_out and alu_operation go to 0 immediately, without waiting for a clock edge.
